// File: rtl/sync_link_arbiter_if.sv
// Link bundle between the CPU requesters, the arbiter and the peripheral.
//
// Handshake: a CPU raises inSEND_arb[i] (level) with its word on
// inDATA_arb[i*DW +: DW] and keeps it up until it sees outDONE_arb[i].
// The arbiter owns the link while outGRANT_arb is non-zero, pulses
// outSEND_arb for one cycle with outDATA_arb valid, then waits for the
// peripheral's inACK_arb (only honoured while waiting). Completion is a
// one-cycle outDONE_arb pulse, with outERR_arb set if no ack arrived.
interface sync_link_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    inSEND_arb;
  logic [NREQ*DW-1:0] inDATA_arb;
  logic               inACK_arb;
  logic               outSEND_arb;
  logic [DW-1:0]      outDATA_arb;
  logic [NREQ-1:0]    outGRANT_arb;
  logic [NREQ-1:0]    outDONE_arb;
  logic               outERR_arb;
  logic [1:0]         dbg_state;

  modport master (
    output inSEND_arb, inDATA_arb, inACK_arb,
    input  outSEND_arb, outDATA_arb, outGRANT_arb, outDONE_arb, outERR_arb,
    input  dbg_state
  );

  modport slave (
    input  inSEND_arb, inDATA_arb, inACK_arb,
    output outSEND_arb, outDATA_arb, outGRANT_arb, outDONE_arb, outERR_arb,
    output dbg_state
  );
endinterface

// File: rtl/sync_link_arbiter.sv
// Round-robin owner of the CPU->peripheral link. Grants one requester,
// strobes its word onto the link, waits (bounded) for the peripheral ack
// and reports completion. All outputs come straight from registers.
module sync_link_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_arb,
  input  logic                rst_arb,
  sync_link_arbiter_if.slave  link
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            send_q, send_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;

  // Round-robin pick: first requester at or cyclically after the pointer.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && link.inSEND_arb[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // State register and all registered outputs; reset clears them at once.
  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      send_q  <= send_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state and next registered outputs; pulses default low, others hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    send_d  = 1'b0;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (found) begin
          owner_d       = pick;
          data_d        = link.inDATA_arb[int'(pick)*DW +: DW];
          grant_d[pick] = 1'b1;
          send_d        = 1'b1;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        // Ack is deliberately not looked at until the strobe has gone out.
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (link.inACK_arb) begin
          done_d[owner_q] = 1'b1;
          state_d         = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
          state_d         = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign link.outSEND_arb  = send_q;
  assign link.outDATA_arb  = data_q;
  assign link.outGRANT_arb = grant_q;
  assign link.outDONE_arb  = done_q;
  assign link.outERR_arb   = err_q;
  assign link.dbg_state    = state_q;

endmodule

// File: tb/tb_sync_link_arbiter.sv
// Bench for sync_link_arbiter: transaction-level model plus directed and
// randomized stimulus.
module tb_sync_link_arbiter;
  localparam int NREQ    = 2;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk_arb = 1'b0;
  logic rst_arb = 1'b0;
  always #5 clk_arb = ~clk_arb;

  sync_link_arbiter_if #(.NREQ(NREQ), .DW(DW)) link();

  sync_link_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_arb (clk_arb),
    .rst_arb (rst_arb),
    .link    (link)
  );

  // ---------------- counters / scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [NREQ-1:0] exp_q[$];
  logic            exp_err_q[$];
  int              exp_wait_q[$];
  logic [DW-1:0]   exp_ddata_q[$];
  logic [NREQ-1:0] exp_sg_q[$];
  logic [DW-1:0]   exp_sd_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
  endfunction

  // ---------------- transaction-level model ----------------
  // A transaction is described by the edge it was granted on (m_t0) and the
  // edge its completion was reported on (m_tdone); all outputs follow from
  // the distance to those edges.
  int              m_owner;
  int              m_ptr;
  int              m_t0;
  int              m_tdone;
  int              ecount;
  logic [DW-1:0]   m_data;
  logic            exp_send;
  logic            exp_err;
  logic [NREQ-1:0] exp_grant;
  logic [NREQ-1:0] exp_done;
  logic [DW-1:0]   exp_data;

  always @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      m_owner = -1; m_ptr = 0; m_t0 = 0; m_tdone = -1; ecount = 0;
      m_data = '0; exp_send = 1'b0; exp_err = 1'b0;
      exp_grant = '0; exp_done = '0; exp_data = '0;
    end else begin
      ecount++;
      exp_send = 1'b0; exp_done = '0; exp_err = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_owner < 0 && link.inSEND_arb[(m_ptr + k) % NREQ]) begin
            m_owner  = (m_ptr + k) % NREQ;
            m_data   = link.inDATA_arb[m_owner*DW +: DW];
            m_t0     = ecount;
            m_tdone  = -1;
            exp_send = 1'b1;
          end
        end
      end else if (m_tdone >= 0) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_tdone = -1;
      end else if (ecount - m_t0 >= 2) begin
        // ecount - m_t0 - 1 wait cycles have now elapsed
        if (link.inACK_arb || (ecount - m_t0 - 1) == TIMEOUT) begin
          m_tdone           = ecount;
          exp_done[m_owner] = 1'b1;
          exp_err           = !link.inACK_arb;
        end
      end
      exp_grant = '0;
      if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
      exp_data = m_data;
    end
  end

  // ---------------- compare process ----------------
  int wait_cnt = 0;
  bit end_req  = 1'b0;
  bit end_seen = 1'b0;

  always begin
    @(negedge clk_arb or negedge rst_arb);
    #1;
    if (!rst_arb) begin
      check("rst_send",  64'(link.outSEND_arb),  64'd0);
      check("rst_data",  64'(link.outDATA_arb),  64'd0);
      check("rst_grant", 64'(link.outGRANT_arb), 64'd0);
      check("rst_done",  64'(link.outDONE_arb),  64'd0);
      check("rst_err",   64'(link.outERR_arb),   64'd0);
      wait_cnt = 0;
    end else begin
      check("send",  64'(link.outSEND_arb),  64'(exp_send));
      check("data",  64'(link.outDATA_arb),  64'(exp_data));
      check("grant", 64'(link.outGRANT_arb), 64'(exp_grant));
      check("done",  64'(link.outDONE_arb),  64'(exp_done));
      check("err",   64'(link.outERR_arb),   64'(exp_err));
      if (link.outSEND_arb && exp_sg_q.size() > 0) begin
        check("sb_grant_at_send", 64'(link.outGRANT_arb), 64'(exp_sg_q.pop_front()));
        check("sb_data_at_send",  64'(link.outDATA_arb),  64'(exp_sd_q.pop_front()));
      end
      if (link.outGRANT_arb != '0 && !link.outSEND_arb && link.outDONE_arb == '0)
        wait_cnt++;
      if (link.outDONE_arb != '0) begin
        if (exp_q.size() > 0) begin
          check("sb_done",     64'(link.outDONE_arb), 64'(exp_q.pop_front()));
          check("sb_err",      64'(link.outERR_arb),  64'(exp_err_q.pop_front()));
          check("sb_wait_len", 64'(wait_cnt),         64'(exp_wait_q.pop_front()));
          check("sb_data_done", 64'(link.outDATA_arb), 64'(exp_ddata_q.pop_front()));
        end
        wait_cnt = 0;
      end
    end
    if (end_req && !end_seen) begin
      check("sb_done_drained", 64'(exp_q.size()),    64'd0);
      check("sb_send_drained", 64'(exp_sg_q.size()), 64'd0);
      end_seen = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_arb);
  endtask

  task automatic expect_send(input logic [NREQ-1:0] g, input logic [DW-1:0] d);
    exp_sg_q.push_back(g);
    exp_sd_q.push_back(d);
  endtask

  task automatic expect_txn(input logic [NREQ-1:0] g, input logic [DW-1:0] d,
                            input logic e, input int w);
    expect_send(g, d);
    exp_q.push_back(g);
    exp_err_q.push_back(e);
    exp_wait_q.push_back(w);
    exp_ddata_q.push_back(d);
  endtask

  task automatic wait_send(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_arb);
      if (link.outSEND_arb) break;
    end
    if (i == budget) begin
      $display("FAIL wait_send: no send strobe within %0d cycles", budget);
      $fatal(1, "send strobe never seen");
    end
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_arb);
      if (link.outDONE_arb != '0) break;
    end
    if (i == budget) begin
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
      $fatal(1, "done pulse never seen");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    link.inSEND_arb = '0;
    link.inDATA_arb = '0;
    link.inACK_arb  = 1'b0;
    tick(3);
    rst_arb = 1'b1;
    tick(2);

    // Single request, ack raised in the second wait cycle.
    expect_txn(2'b01, 32'hDEADBEEF, 1'b0, 2);
    link.inDATA_arb = {32'h0000_0000, 32'hDEADBEEF};
    link.inSEND_arb = 2'b01;
    wait_send(5);
    tick(2);
    link.inACK_arb = 1'b1;
    wait_done(5);
    link.inACK_arb  = 1'b0;
    link.inSEND_arb = '0;
    tick(2);

    // Contention from a fresh pointer: grants alternate 01,10,01,10.
    rst_arb = 1'b0;
    tick(2);
    rst_arb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_txn(2'b01, 32'h1111_1111, 1'b0, 1);
      else            expect_txn(2'b10, 32'h2222_2222, 1'b0, 1);
    end
    link.inDATA_arb = {32'h2222_2222, 32'h1111_1111};
    link.inACK_arb  = 1'b1;
    link.inSEND_arb = 2'b11;
    tick(16);
    link.inSEND_arb = '0;
    link.inACK_arb  = 1'b0;
    tick(2);

    // Timeout on CPU1, then a normal transfer.
    expect_txn(2'b10, 32'hCAFE_0001, 1'b1, TIMEOUT);
    link.inDATA_arb = {32'hCAFE_0001, 32'h0000_0000};
    link.inSEND_arb = 2'b10;
    wait_done(40);
    link.inSEND_arb = '0;
    expect_txn(2'b01, 32'h0000_5A5A, 1'b0, 1);
    link.inDATA_arb = {32'h0000_0000, 32'h0000_5A5A};
    link.inSEND_arb = 2'b01;
    link.inACK_arb  = 1'b1;
    wait_done(10);
    link.inSEND_arb = '0;
    link.inACK_arb  = 1'b0;
    tick(1);

    // Ack only in the last allowed wait cycle wins over the timeout.
    expect_txn(2'b01, 32'h1515_1515, 1'b0, TIMEOUT);
    link.inDATA_arb = {32'h0000_0000, 32'h1515_1515};
    link.inSEND_arb = 2'b01;
    wait_send(5);
    tick(TIMEOUT);
    link.inACK_arb = 1'b1;
    wait_done(3);
    link.inACK_arb  = 1'b0;
    link.inSEND_arb = '0;
    tick(1);

    // Ack only during the send strobe is ignored: times out.
    expect_txn(2'b01, 32'h0A0A_0A0A, 1'b1, TIMEOUT);
    link.inDATA_arb = {32'h0000_0000, 32'h0A0A_0A0A};
    link.inSEND_arb = 2'b01;
    wait_send(5);
    link.inACK_arb = 1'b1;
    tick(1);
    link.inACK_arb = 1'b0;
    wait_done(40);
    link.inSEND_arb = '0;
    tick(1);

    // Reset in the middle of a wait: abandoned, then CPU1 served first.
    expect_send(2'b01, 32'h7777_7777);
    link.inDATA_arb = {32'h8888_8888, 32'h7777_7777};
    link.inSEND_arb = 2'b01;
    wait_send(5);
    tick(3);
    @(posedge clk_arb);
    #2;
    rst_arb = 1'b0;
    link.inSEND_arb = 2'b10;
    tick(2);
    rst_arb = 1'b1;
    expect_txn(2'b10, 32'h8888_8888, 1'b0, 1);
    link.inACK_arb = 1'b1;
    wait_done(10);
    link.inACK_arb  = 1'b0;
    link.inSEND_arb = '0;
    tick(1);

    // Input word and request change while waiting; latched word is kept.
    expect_txn(2'b01, 32'hA5A5_0001, 1'b0, 3);
    link.inDATA_arb = {32'h0000_0000, 32'hA5A5_0001};
    link.inSEND_arb = 2'b01;
    wait_send(5);
    tick(1);
    link.inDATA_arb = {32'hFFFF_FFFF, 32'h1234_5678};
    link.inSEND_arb = '0;
    tick(2);
    link.inACK_arb = 1'b1;
    wait_done(3);
    link.inACK_arb = 1'b0;
    tick(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_arb);
      link.inSEND_arb = 2'($urandom_range(0, 3));
      link.inDATA_arb = {$urandom(), $urandom()};
      if (i < 300) link.inACK_arb = ($urandom_range(0, 3) == 0);
      else         link.inACK_arb = ($urandom_range(0, 19) == 0);
    end
    link.inSEND_arb = '0;
    link.inACK_arb  = 1'b1;
    tick(10);
    link.inACK_arb = 1'b0;
    tick(2);

    end_req = 1'b1;
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
